// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: FIFO-buffered stereo PCM feeder that releases one sample pair
// per programmable period and holds it steady for two sigma-delta DAC channels.
module audio_sample_feeder #(
    parameter int NBITS      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [DIV_W-1:0]              div_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    input  logic [2*NBITS-1:0]            in_data_i,
    output logic                          in_ready_o,
    output logic [NBITS-1:0]              left_o,
    output logic [NBITS-1:0]              right_o,
    output logic                          sample_tick_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          underrun_o,
    input  logic                          underrun_clr_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [2*NBITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [LW-1:0]      r_level;
    logic [DIV_W-1:0]   r_count;
    logic               r_tick;
    logic [NBITS-1:0]   r_left;
    logic [NBITS-1:0]   r_right;
    logic               r_sample_tick;
    logic               r_underrun;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_under;
    logic [LW-1:0]      w_level_nxt;

    // A flush in the same cycle as a tick counts as an empty pop.
    always_comb begin
        w_full      = r_level == LW'(FIFO_DEPTH);
        w_empty     = r_level == '0;
        w_push      = in_valid_i && !w_full && !flush_i;
        w_pop       = r_tick && !w_empty && !flush_i;
        w_under     = r_tick && (w_empty || flush_i);
        w_level_nxt = flush_i            ? '0 :
                      (w_push && !w_pop) ? r_level + LW'(1) :
                      (!w_push && w_pop) ? r_level - LW'(1) : r_level;
    end

    // >= compare lets a shrinking div_i tick immediately instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (!enable_i) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count >= div_i) begin
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + DIV_W'(1);
            r_tick  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= flush_i ? '0 : r_wptr + AW'(w_push);
            r_rptr  <= flush_i ? '0 : r_rptr + AW'(w_pop);
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= in_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_left        <= '0;
            r_right       <= '0;
            r_sample_tick <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_left  <= r_mem[r_rptr][NBITS-1:0];
                r_right <= r_mem[r_rptr][2*NBITS-1:NBITS];
            end else if (w_under) begin
                r_left  <= '0;
                r_right <= '0;
            end
            r_sample_tick <= r_tick;
            r_underrun    <= w_under ? 1'b1 : underrun_clr_i ? 1'b0 : r_underrun;
        end
    end

    assign in_ready_o    = !w_full;
    assign left_o        = r_left;
    assign right_o       = r_right;
    assign sample_tick_o = r_sample_tick;
    assign level_o       = r_level;
    assign underrun_o    = r_underrun;
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder: directed and randomized checks of the sample feeder against
// a queue-based model with an arithmetic tick schedule.
module tb_audio_sample_feeder;
    localparam int N  = 16;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int LW = $clog2(D) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic [DW-1:0] div_i = '0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [2*N-1:0] in_data_i = '0;
    logic          in_ready_o;
    logic [N-1:0]  left_o;
    logic [N-1:0]  right_o;
    logic          sample_tick_o;
    logic [LW-1:0] level_o;
    logic          underrun_o;
    logic          underrun_clr_i = 1'b0;

    audio_sample_feeder #(.NBITS(N), .FIFO_DEPTH(D), .DIV_W(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .div_i(div_i),
        .flush_i(flush_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o), .left_o(left_o), .right_o(right_o),
        .sample_tick_o(sample_tick_o), .level_o(level_o), .underrun_o(underrun_o),
        .underrun_clr_i(underrun_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*N-1:0] m_q[$];
    logic [N-1:0]   m_left;
    logic [N-1:0]   m_right;
    bit             m_und;
    bit             m_acc;

    // Output update n edges after enable rises (count starting at 0).
    function automatic bit tick_exp(input int n, input int d);
        return n >= d + 2 && ((n - d - 2) % (d + 1)) == 0;
    endfunction

    // Advance one clock edge, applying the behavioural rules to the model.
    task automatic step(input bit pop_now);
        bit push;
        bit set_und;
        logic [2*N-1:0] h;
        push    = in_valid_i && m_q.size() < D && !flush_i;
        set_und = pop_now && (flush_i || m_q.size() == 0);
        m_acc   = push;
        if (pop_now && !set_und) begin
            h = m_q.pop_front();
            m_left  = h[N-1:0];
            m_right = h[2*N-1:N];
        end else if (set_und) begin
            m_left  = '0;
            m_right = '0;
        end
        m_und = set_und ? 1'b1 : underrun_clr_i ? 1'b0 : m_und;
        if (flush_i) m_q.delete();
        if (push) m_q.push_back(in_data_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        enable_i = 1'b0; div_i = '0; flush_i = 1'b0; in_valid_i = 1'b0;
        in_data_i = '0; underrun_clr_i = 1'b0;
        m_q.delete(); m_left = '0; m_right = '0; m_und = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (level_o !== '0) begin n_fail++; $display("FAIL rst_level: got %0d exp 0", level_o); end
        n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", in_ready_o); end
        n_tests++; if ({left_o, right_o, sample_tick_o, underrun_o} !== '0) begin n_fail++; $display("FAIL rst_outs: got %h/%h/%b/%b exp 0", left_o, right_o, sample_tick_o, underrun_o); end
        div_i = 3;
        in_data_i = 32'h5678_1234;
        in_valid_i = 1'b1;
        step(1'b0);
        in_valid_i = 1'b0;
        enable_i = 1'b1;
        for (int n = 1; n <= 5; n++) step(tick_exp(n, 3));
        enable_i = 1'b0;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data_i = $urandom;
            step(1'b0);
        end
        in_valid_i = 1'b0;
        n_tests++; if (level_o !== LW'(5)) begin n_fail++; $display("FAIL pre_rst_level: got %0d exp 5", level_o); end
        n_tests++; if (left_o !== 16'h1234) begin n_fail++; $display("FAIL pre_rst_left: got %h exp 1234", left_o); end
        rst_i = 1'b1;
        #2;
        n_tests++; if (level_o !== '0 || left_o !== '0 || underrun_o !== 1'b0) begin n_fail++; $display("FAIL async_rst: got level %0d left %h und %b exp 0", level_o, left_o, underrun_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b exp 1", in_ready_o); end
    endtask

    task automatic test_steady_rate();
        bit e;
        do_reset();
        div_i = 9;
        in_valid_i = 1'b1;
        in_data_i = {16'h8000, 16'h7FFF};
        step(1'b0);
        in_data_i = {16'h0001, 16'hFFFF};
        step(1'b0);
        in_valid_i = 1'b0;
        enable_i = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            e = tick_exp(n, 9);
            step(e);
            n_tests++; if (sample_tick_o !== e) begin n_fail++; $display("FAIL steady_tick n=%0d: got %b exp %b", n, sample_tick_o, e); end
            if (n == 11) begin
                n_tests++; if ({right_o, left_o} !== 32'h8000_7FFF) begin n_fail++; $display("FAIL steady_pair1: got %h/%h exp 7fff/8000", left_o, right_o); end
            end
            if (n == 21) begin
                n_tests++; if ({right_o, left_o} !== 32'h0001_FFFF) begin n_fail++; $display("FAIL steady_pair2: got %h/%h exp ffff/0001", left_o, right_o); end
            end
        end
    endtask

    task automatic test_fill();
        logic [2*N-1:0] data [17];
        int idx;
        int acc_n;
        bit e;
        do_reset();
        foreach (data[i]) data[i] = $urandom;
        idx = 0;
        acc_n = -1;
        in_valid_i = 1'b1;
        in_data_i = data[0];
        for (int c = 0; c < 19; c++) begin
            step(1'b0);
            if (m_acc) begin idx++; in_data_i = data[idx]; end
            n_tests++; if (level_o !== LW'(m_q.size())) begin n_fail++; $display("FAIL fill_level c=%0d: got %0d exp %0d", c, level_o, m_q.size()); end
        end
        n_tests++; if (in_ready_o !== 1'b0 || level_o !== LW'(16)) begin n_fail++; $display("FAIL fill_full: got ready %b level %0d exp 0/16", in_ready_o, level_o); end
        div_i = 0;
        enable_i = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            e = tick_exp(n, 0);
            step(e);
            if (m_acc) begin idx++; acc_n = n; in_valid_i = 1'b0; end
            n_tests++; if (sample_tick_o !== e || {right_o, left_o} !== {m_right, m_left} || level_o !== LW'(m_q.size()) || underrun_o !== m_und) begin
                n_fail++; $display("FAIL drain n=%0d: got tick %b data %h%h level %0d und %b exp %b %h%h %0d %b", n, sample_tick_o, right_o, left_o, level_o, underrun_o, e, m_right, m_left, m_q.size(), m_und);
            end
        end
        n_tests++; if (acc_n != 3) begin n_fail++; $display("FAIL fill_17th_accept: got edge %0d exp 3", acc_n); end
    endtask

    task automatic test_underrun();
        do_reset();
        div_i = 3;
        in_valid_i = 1'b1;
        in_data_i = $urandom;
        step(1'b0);
        in_valid_i = 1'b0;
        enable_i = 1'b1;
        for (int n = 1; n <= 9; n++) step(tick_exp(n, 3));
        n_tests++; if (left_o !== '0 || right_o !== '0 || underrun_o !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %h/%h und %b exp 0/0/1", left_o, right_o, underrun_o); end
        for (int n = 10; n <= 12; n++) step(tick_exp(n, 3));
        underrun_clr_i = 1'b1;
        step(tick_exp(13, 3));
        underrun_clr_i = 1'b0;
        n_tests++; if (underrun_o !== 1'b1 || sample_tick_o !== 1'b1) begin n_fail++; $display("FAIL underrun_set_wins: got und %b tick %b exp 1/1", underrun_o, sample_tick_o); end
        underrun_clr_i = 1'b1;
        step(tick_exp(14, 3));
        underrun_clr_i = 1'b0;
        n_tests++; if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b exp 0", underrun_o); end
    endtask

    task automatic test_div_change();
        bit e;
        do_reset();
        div_i = 99;
        enable_i = 1'b1;
        for (int n = 1; n <= 40; n++) step(1'b0);
        n_tests++; if (sample_tick_o !== 1'b0) begin n_fail++; $display("FAIL div_quiet: got %b exp 0", sample_tick_o); end
        div_i = 10;
        for (int n = 41; n <= 64; n++) begin
            e = n == 42 || (n > 42 && (n - 42) % 11 == 0);
            step(e);
            n_tests++; if (sample_tick_o !== e || underrun_o !== m_und) begin n_fail++; $display("FAIL div_change n=%0d: got tick %b und %b exp %b %b", n, sample_tick_o, underrun_o, e, m_und); end
        end
    endtask

    task automatic test_flush_push();
        do_reset();
        div_i = 3;
        in_valid_i = 1'b1;
        in_data_i = 32'hA5A5_5A5A;
        step(1'b0);
        in_valid_i = 1'b0;
        enable_i = 1'b1;
        for (int n = 1; n <= 5; n++) step(tick_exp(n, 3));
        enable_i = 1'b0;
        in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = $urandom;
            step(1'b0);
        end
        n_tests++; if (level_o !== LW'(4)) begin n_fail++; $display("FAIL flush_pre_level: got %0d exp 4", level_o); end
        flush_i = 1'b1;
        in_data_i = $urandom;
        step(1'b0);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        n_tests++; if (level_o !== '0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_level: got level %0d ready %b exp 0/1", level_o, in_ready_o); end
        n_tests++; if ({right_o, left_o} !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL flush_hold: got %h%h exp a5a55a5a", right_o, left_o); end
        step(1'b0);
        n_tests++; if (level_o !== '0) begin n_fail++; $display("FAIL flush_no_push: got %0d exp 0", level_o); end
    endtask

    task automatic test_random();
        int d;
        bit e;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            d = $urandom_range(0, 4);
            div_i = DW'(d);
            enable_i = 1'b1;
            for (int n = 1; n <= 150; n++) begin
                if (!in_valid_i && $urandom_range(0, 2) != 0) begin
                    in_valid_i = 1'b1;
                    in_data_i = $urandom;
                end
                flush_i = $urandom_range(0, 40) == 0;
                underrun_clr_i = $urandom_range(0, 15) == 0;
                e = tick_exp(n, d);
                step(e);
                if (m_acc) in_valid_i = 1'b0;
                n_tests++; if (sample_tick_o !== e || {right_o, left_o} !== {m_right, m_left} || level_o !== LW'(m_q.size()) || underrun_o !== m_und || in_ready_o !== (m_q.size() < D)) begin
                    n_fail++; $display("FAIL random d=%0d n=%0d: got tick %b data %h%h level %0d und %b exp %b %h%h %0d %b", d, n, sample_tick_o, right_o, left_o, level_o, underrun_o, e, m_right, m_left, m_q.size(), m_und);
                end
            end
            flush_i = 1'b0;
            underrun_clr_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_steady_rate();
        test_fill();
        test_underrun();
        test_div_change();
        test_flush_push();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
